// File: rtl/n64adv_vout_align_if.sv
// n64adv_vout_align_if: pixel-domain bus between colour conversion and the output pins.
// Inputs to the stage:  pix_en, vdata_i (ch0 in MSBs), sync_i {nVS,nCLAMP/nBLANK,nHS,nCS},
//   cfg_vdly/cfg_sdly (extra delay stages), cfg_blank_en, cfg_filter, linedbl_en.
// Outputs of the stage: vdata_o, sync_o, filter_o {F1,F2}, resync_o.
interface n64adv_vout_align_if #(
  parameter int COLOR_W = 8,
  parameter int NUM_CH  = 3,
  parameter int DLY_W   = 2
);
  logic                      pix_en;
  logic [NUM_CH*COLOR_W-1:0] vdata_i;
  logic [3:0]                sync_i;
  logic [DLY_W-1:0]          cfg_vdly;
  logic [DLY_W-1:0]          cfg_sdly;
  logic                      cfg_blank_en;
  logic [1:0]                cfg_filter;
  logic                      linedbl_en;
  logic [NUM_CH*COLOR_W-1:0] vdata_o;
  logic [3:0]                sync_o;
  logic [1:0]                filter_o;
  logic                      resync_o;
  modport master (
    output pix_en, vdata_i, sync_i, cfg_vdly, cfg_sdly, cfg_blank_en, cfg_filter, linedbl_en,
    input  vdata_o, sync_o, filter_o, resync_o
  );
  modport slave (
    input  pix_en, vdata_i, sync_i, cfg_vdly, cfg_sdly, cfg_blank_en, cfg_filter, linedbl_en,
    output vdata_o, sync_o, filter_o, resync_o
  );
endinterface

// File: rtl/n64adv_vout_align.sv
// n64adv_vout_align: output stage aligning video and sync through programmable delay lines.
// Ports: VCLK pixel clock, nRST async active-low reset, bus (slave side of n64adv_vout_align_if).
// Video is muted from any delay change until the first delayed vsync fall after a flush;
// the filter select only changes on that same delayed vsync fall.
module n64adv_vout_align #(
  parameter int COLOR_W = 8,
  parameter int NUM_CH  = 3,
  parameter int DLY_W   = 2
) (
  input logic VCLK,
  input logic nRST,
  n64adv_vout_align_if.slave bus
);
  localparam int MAX_DLY = (1 << DLY_W) - 1;
  localparam int VW = NUM_CH * COLOR_W;
  localparam int CW = DLY_W + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MAX_DLY + 1);
  typedef enum logic [1:0] {RUN, FLUSH, WAIT_VS} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DLY_W-1:0] act_vdly, act_sdly;
  logic [VW-1:0] vline [MAX_DLY+1];
  logic [3:0] sline [MAX_DLY+1];
  logic [VW-1:0] vtap, vdata_nxt;
  logic [3:0] stap;
  logic vs_prev, vs_fall, cfg_chg;
  logic [1:0] filter_tgt;
  assign vtap = vline[act_vdly];
  assign stap = sline[act_sdly];
  assign cfg_chg = (bus.cfg_vdly != act_vdly) || (bus.cfg_sdly != act_sdly);
  assign vs_fall = bus.pix_en & vs_prev & ~stap[3];
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      state <= FLUSH;
      cnt <= CNT_INIT;
      act_vdly <= '0;
      act_sdly <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      act_vdly <= bus.cfg_vdly;
      act_sdly <= bus.cfg_sdly;
    end
  end
  // a delay change restarts the flush from any state and wins over every other transition
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (cfg_chg) begin
      state_nxt = FLUSH;
      cnt_nxt = CNT_INIT;
    end else if (state == FLUSH && bus.pix_en) begin
      cnt_nxt = cnt - CW'(1);
      state_nxt = (cnt == CW'(1)) ? WAIT_VS : FLUSH;
    end else if (state == WAIT_VS && vs_fall) begin
      state_nxt = RUN;
    end
  end
  // gating on the next state lets the first RUN pixel be registered on the vsync edge itself
  always_comb begin
    vdata_nxt = (state_nxt == RUN && !(bus.cfg_blank_en && !stap[2])) ? vtap : '0;
    filter_tgt = (bus.cfg_filter == 2'b11) ? 2'b11 :
                 (bus.cfg_filter == 2'b10) ? 2'b01 :
                 (bus.cfg_filter == 2'b01) ? 2'b00 : {1'b0, bus.linedbl_en};
  end
  assign bus.resync_o = (state != RUN);
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k <= MAX_DLY; k++) begin
        vline[k] <= '0;
        sline[k] <= '0;
      end
      bus.vdata_o <= '0;
      bus.sync_o <= '0;
      bus.filter_o <= '0;
      vs_prev <= 1'b0;
    end else if (bus.pix_en) begin
      vline[0] <= bus.vdata_i;
      sline[0] <= bus.sync_i;
      for (int k = 1; k <= MAX_DLY; k++) begin
        vline[k] <= vline[k-1];
        sline[k] <= sline[k-1];
      end
      bus.vdata_o <= vdata_nxt;
      bus.sync_o <= stap;
      vs_prev <= stap[3];
      if (vs_fall) bus.filter_o <= filter_tgt;
    end
  end
endmodule

// File: tb/tb_n64adv_vout_align.sv
// tb_n64adv_vout_align: randomized bench against a history-based reference model of the output stage.
module tb_n64adv_vout_align;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  n64adv_vout_align_if bus ();
  n64adv_vout_align dut (.VCLK(clk), .nRST(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference: every captured pixel is kept, outputs are looked up by age
  logic [23:0] vh [0:8191];
  logic [3:0] sh [0:8191];
  int n, mv, ms, phase, left;
  bit vsp;
  logic [23:0] exp_v;
  logic [3:0] exp_s;
  logic [1:0] exp_f;
  logic [1:0] ftab [4];
  function automatic logic [23:0] vage(input int a);
    return (n - 1 - a >= 0) ? vh[n-1-a] : 24'h0;
  endfunction
  function automatic logic [3:0] sage(input int a);
    return (n - 1 - a >= 0) ? sh[n-1-a] : 4'h0;
  endfunction
  task automatic model_reset();
    n = 0; mv = 0; ms = 0; phase = 1; left = 4; vsp = 0;
    exp_v = 0; exp_s = 0; exp_f = 0;
  endtask
  task automatic model_step();
    logic [23:0] vt;
    logic [3:0] st;
    bit fall;
    vt = vage(mv);
    st = sage(ms);
    fall = bus.pix_en && vsp && !st[3];
    ftab[0] = bus.linedbl_en ? 2'b01 : 2'b00;
    ftab[1] = 2'b00; ftab[2] = 2'b01; ftab[3] = 2'b11;
    if (int'(bus.cfg_vdly) != mv || int'(bus.cfg_sdly) != ms) begin
      mv = bus.cfg_vdly; ms = bus.cfg_sdly; phase = 1; left = 4;
    end else if (phase == 1 && bus.pix_en) begin
      left--;
      if (left == 0) phase = 2;
    end else if (phase == 2 && fall) phase = 0;
    if (bus.pix_en) begin
      exp_v = (phase == 0 && !(bus.cfg_blank_en && !st[2])) ? vt : 24'h0;
      exp_s = st;
      vsp = st[3];
      if (fall) exp_f = ftab[bus.cfg_filter];
      vh[n] = bus.vdata_i;
      sh[n] = bus.sync_i;
      n++;
    end
  endtask
  task automatic check_reset_vals();
    chk("rst_vdata", {8'h0, bus.vdata_o}, 32'h0);
    chk("rst_sync", {28'h0, bus.sync_o}, 32'h0);
    chk("rst_filter", {30'h0, bus.filter_o}, 32'h0);
    chk("rst_resync", {31'h0, bus.resync_o}, 32'h1);
  endtask
  initial begin
    int vc;
    bit did_wait_rst, did_run_rst;
    int runs;
    vc = 0; did_wait_rst = 0; did_run_rst = 0; runs = 0;
    bus.pix_en = 0; bus.vdata_i = 0; bus.sync_i = 4'hF;
    bus.cfg_vdly = 0; bus.cfg_sdly = 0; bus.cfg_blank_en = 0;
    bus.cfg_filter = 0; bus.linedbl_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      chk("vdata", {8'h0, bus.vdata_o}, {8'h0, exp_v});
      chk("sync", {28'h0, bus.sync_o}, {28'h0, exp_s});
      chk("filter", {30'h0, bus.filter_o}, {30'h0, exp_f});
      chk("resync", {31'h0, bus.resync_o}, {31'h0, phase != 0});
      if (phase == 0) runs++;
      if ((c > 1000 && phase == 2 && !did_wait_rst) || (c > 3000 && phase == 0 && !did_run_rst)) begin
        if (phase == 2) did_wait_rst = 1; else did_run_rst = 1;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      vc++;
      bus.pix_en = ($urandom_range(0, 9) != 0);
      bus.vdata_i = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      bus.sync_i = {(vc % 64) >= 6, !((vc % 64) >= 40 && (vc % 64) < 50), 2'($urandom)};
      if ($urandom_range(0, 299) == 0) begin
        bus.cfg_vdly = 2'($urandom);
        bus.cfg_sdly = 2'($urandom);
      end
      if ($urandom_range(0, 199) == 0) bus.cfg_blank_en = ~bus.cfg_blank_en;
      if ($urandom_range(0, 149) == 0) bus.cfg_filter = 2'($urandom);
      if ($urandom_range(0, 99) == 0) bus.linedbl_en = ~bus.linedbl_en;
      model_step();
    end
    chk("run_reached", {31'h0, runs > 100}, 32'h1);
    chk("rst_wait_hit", {31'h0, did_wait_rst}, 32'h1);
    chk("rst_run_hit", {31'h0, did_run_rst}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/n64adv_vout_align.md
Name: n64adv_vout_align

Overview:
Parametrised final output stage of the PPU. It sits after colour conversion and before the DAC pins. Video and sync pass through independently programmable delay lines so each can be aligned to the other. Video is muted through a flush/resync sequence whenever the delays change, and the video filter selection is updated only on frame boundaries.

Parameters:
COLOR_W, 8, bits per colour channel.
NUM_CH, 3, number of colour channels.
DLY_W, 2, width of the delay selects; MAX_DLY = 2^DLY_W - 1 extra pixel stages.

Ports:
VCLK  in  1  pixel-domain clock.
nRST  in  1  reset, asynchronous assert, active-low.
pix_en  in  1  pixel enable; all delay lines, counters and edge detectors advance only when high.
vdata_i  in  NUM_CH*COLOR_W  colour data, channel 0 in the MSBs.
sync_i  in  4  {nVSYNC, nCLAMP/nBLANK, nHSYNC, nCSYNC}, all active-low.
cfg_vdly  in  DLY_W  extra video delay, in pixel stages.
cfg_sdly  in  DLY_W  extra sync delay, in pixel stages.
cfg_blank_en  in  1  forces colour to 0 while the delayed sync bit 2 is low.
cfg_filter  in  2  00 auto, 01 9.5 MHz, 10 18 MHz, 11 bypass.
linedbl_en  in  1  line doubler active; used only in auto filter mode.
vdata_o  out  NUM_CH*COLOR_W  aligned colour.
sync_o  out  4  aligned sync, same bit order as sync_i.
filter_o  out  2  {F1,F2} filter control.
resync_o  out  1  high while the state is not RUN.

Behaviour:
- Reset values: vdata_o=0, sync_o=4'b0000, filter_o=2'b00, resync_o=1. Delay lines are all 0. Active delays act_vdly=act_sdly=0. State is FLUSH with cnt=MAX_DLY+1. vs_prev=0.
- Delay lines:
  - Video line: MAX_DLY+1 registers. Tap k is taken after k+1 registers.
  - vdata_o is registered from tap act_vdly, giving latency 2+act_vdly pix_en cycles.
  - Sync line works the same way with act_sdly; sync_o latency is 2+act_sdly.
  - When pix_en=0, every register (outputs included) holds.
- Config change detection:
  - Evaluated every VCLK, independent of pix_en.
  - If cfg_vdly!=act_vdly or cfg_sdly!=act_sdly: latch both into act_*, set cnt=MAX_DLY+1, and go to FLUSH from any state.
  - This takes priority over every other transition in the same cycle.
- States:
  - RUN: normal output. resync_o=0.
  - FLUSH: vdata_o forced to 0; sync_o still follows its delay line (the sink must not lose lock). cnt decrements on each pix_en. When cnt reaches 0, go to WAIT_VS.
  - WAIT_VS: vdata_o forced to 0. On a falling edge of the delayed vsync (vs_prev=1, tap value of bit 3 = 0, pix_en=1), go to RUN. The first RUN output is registered in the same cycle as the edge.
- Blanking: in RUN with cfg_blank_en=1, if the sync tap bit 2 is 0, the registered vdata_o is 0. Blanking uses the sync tap at act_sdly.
- Filter target, combinational:
  - cfg_filter 11 -> 11.
  - cfg_filter 10 -> 01.
  - cfg_filter 01 -> 00.
  - cfg_filter 00 -> 01 if linedbl_en, else 00.
- Filter update timing:
  - filter_o loads the target only on the delayed-vsync falling edge defined above, in any state.
  - Otherwise filter_o holds, so mid-frame config changes wait for the next frame.
- vs_prev updates with the sync tap bit 3 on each pix_en. It resets to 0, so no edge is detected before a high is seen.
- Reset asserted mid-frame: all registers return to their reset values immediately (async). The FLUSH sequence restarts after release.
- MAX_DLY+1 flush cycles guarantee that no sample latched under the old delay setting reaches vdata_o.

Test Plan:
- Defaults (DLY_W=2), cfg_vdly=cfg_sdly=0, pix_en=1, vsync toggling every 64 pixels -> resync_o=1 for 4 FLUSH cycles, then until the first delayed nVSYNC fall. vdata_o then equals vdata_i delayed 2 cycles.
- In RUN, set cfg_vdly=2, cfg_sdly=0 -> resync_o rises next cycle and vdata_o=0 until the next vsync fall. Afterwards video latency is 4 and sync latency is 2.
- pix_en pattern 1,0,0,1 with ramp data 0x10,0x11 -> outputs hold during pix_en=0. Latency counts only enabled cycles, and cnt does not decrement while pix_en=0.
- cfg_filter=00, linedbl_en toggled 0->1 mid-frame -> filter_o stays 00 until the delayed nVSYNC fall, then becomes 01. Setting cfg_filter=11 gives 11 at the following frame.
- cfg_blank_en=1, sync_i bit 2 low for 10 pixels with data 0xFFFFFF -> vdata_o=0 for exactly those 10 pixels, shifted by the sync latency.
- Assert nRST during WAIT_VS and during RUN -> all outputs go to their reset values asynchronously. After release the flush sequence repeats: 4 cycles, then wait for vsync.
